// File: rtl/fp_div_issue.sv
// Issue/capture stage around fp_divider: valid/ready operand intake,
// fixed-latency wait, quotient capture with tag and IEEE class flags.
module fp_div_issue #(
    parameter int unsigned DIV_LATENCY = 1,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic [31:0]      div_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [3:0]       res_flags,
    output logic             busy
);

    if (DIV_LATENCY < 1 || DIV_LATENCY > 15) begin : g_bad_latency
        $error("fp_div_issue: DIV_LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    logic [3:0]       rflags_q, rflags_d;
    logic             accept;
    logic [3:0]       flags_now;

    // Flags: {nan, inf, zero, div_by_zero}; operands come from the held registers
    always_comb begin
        flags_now[3] = (div_out[30:23] == 8'hFF) && (div_out[22:0] != 23'd0);
        flags_now[2] = (div_out[30:23] == 8'hFF) && (div_out[22:0] == 23'd0);
        flags_now[1] = (div_out[30:0] == 31'd0);
        flags_now[0] = (b_q[30:0] == 31'd0) && (a_q[30:0] != 31'd0)
                       && (a_q[30:23] != 8'hFF);
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && res_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        rdata_d  = rdata_q;
        rtag_d   = rtag_q;
        rflags_d = rflags_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d  = div_out;
                    rtag_d   = tag_q;
                    rflags_d = flags_now;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A retire in DONE may coincide with the next accept
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            tag_d   = in_tag;
            cnt_d   = 4'(DIV_LATENCY);
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            rdata_q  <= '0;
            rtag_q   <= '0;
            rflags_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            rdata_q  <= rdata_d;
            rtag_q   <= rtag_d;
            rflags_q <= rflags_d;
        end
    end

    assign div_a     = a_q;
    assign div_b     = b_q;
    assign res_valid = (state_q == DONE);
    assign res_data  = rdata_q;
    assign res_tag   = rtag_q;
    assign res_flags = rflags_q;
    assign busy      = (state_q != IDLE);

endmodule
